// File: rtl/img_frame_arbiter.sv
// Frame-granular arbiter: grants one of two RGB888 sources to a shared converter for a
// whole frame, forwards it through one register stage, then forces a flush gap.
module img_frame_arbiter #(
  parameter int MD_SIM_ABLE = 0,
  parameter int MD_ARB_MODE = 0,
  parameter int NUM_GAP_CYC = 4,
  parameter int WD_IMG_DATA = 8,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_reset,
  input  logic                   i_arb_en,
  input  logic                   i_err_clr,
  input  logic                   s0_img_rgb888_c_fsync,
  input  logic                   s0_img_rgb888_c_vsync,
  input  logic                   s0_img_rgb888_c_hsync,
  input  logic [WD_IMG_DATA-1:0] s0_img_rgb888_r_mdat0,
  input  logic [WD_IMG_DATA-1:0] s0_img_rgb888_g_mdat1,
  input  logic [WD_IMG_DATA-1:0] s0_img_rgb888_b_mdat2,
  input  logic                   s1_img_rgb888_c_fsync,
  input  logic                   s1_img_rgb888_c_vsync,
  input  logic                   s1_img_rgb888_c_hsync,
  input  logic [WD_IMG_DATA-1:0] s1_img_rgb888_r_mdat0,
  input  logic [WD_IMG_DATA-1:0] s1_img_rgb888_g_mdat1,
  input  logic [WD_IMG_DATA-1:0] s1_img_rgb888_b_mdat2,
  output logic                   m_img_rgb888_c_fsync,
  output logic                   m_img_rgb888_c_vsync,
  output logic                   m_img_rgb888_c_hsync,
  output logic [WD_IMG_DATA-1:0] m_img_rgb888_r_mdat0,
  output logic [WD_IMG_DATA-1:0] m_img_rgb888_g_mdat1,
  output logic [WD_IMG_DATA-1:0] m_img_rgb888_b_mdat2,
  output logic                   o_grant_src,
  output logic                   o_grant_busy,
  output logic [7:0]             o_drop_cnt0,
  output logic [7:0]             o_drop_cnt1,
  output logic [WD_ERR_INFO-1:0] m_err_arb_info
);

  localparam int GAP_W = (NUM_GAP_CYC > 1) ? $clog2(NUM_GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, GAP} state_t;

  typedef struct packed {
    logic                   fsync;
    logic                   vsync;
    logic                   hsync;
    logic [WD_IMG_DATA-1:0] r;
    logic [WD_IMG_DATA-1:0] g;
    logic [WD_IMG_DATA-1:0] b;
  } pix_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  if (MD_SIM_ABLE != 0) begin : g_sim_able
  end

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             grant_q, grant_d;
  logic             fs_prev0, fs_prev1;
  logic [7:0]       cnt0_q, cnt1_q, cnt0_d, cnt1_d, cnt0_base, cnt1_base;
  logic [3:0]       err_q, err_d, err_base;
  logic             start0, start1;
  logic             drop0, drop1, perr_h, perr_v;
  pix_t             s0_pix, s1_pix, pix_d, pix_p1;

  assign s0_pix = '{s0_img_rgb888_c_fsync, s0_img_rgb888_c_vsync, s0_img_rgb888_c_hsync,
                    s0_img_rgb888_r_mdat0, s0_img_rgb888_g_mdat1, s0_img_rgb888_b_mdat2};
  assign s1_pix = '{s1_img_rgb888_c_fsync, s1_img_rgb888_c_vsync, s1_img_rgb888_c_hsync,
                    s1_img_rgb888_r_mdat0, s1_img_rgb888_g_mdat1, s1_img_rgb888_b_mdat2};

  // A frame already running when reset releases never looks like a start.
  assign start0 = s0_pix.fsync & ~fs_prev0;
  assign start1 = s1_pix.fsync & ~fs_prev1;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    pix_d   = '0;
    drop0   = 1'b0;
    drop1   = 1'b0;
    perr_h  = 1'b0;
    perr_v  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_arb_en) begin
          drop0 = start0;
          drop1 = start1;
        end else if (start0 && (!start1 || MD_ARB_MODE != 0 || grant_q)) begin
          state_d = PASS0;
          grant_d = 1'b0;
          pix_d   = s0_pix;
          drop1   = start1;
        end else if (start1) begin
          state_d = PASS1;
          grant_d = 1'b1;
          pix_d   = s1_pix;
          drop0   = start0;
        end
      end
      PASS0: begin
        pix_d  = s0_pix;
        drop1  = start1;
        perr_h = s0_pix.hsync & ~s0_pix.vsync;
        perr_v = s0_pix.vsync & ~s0_pix.fsync;
        if (!s0_pix.fsync) begin
          state_d = GAP;
          gap_d   = GAP_W'(NUM_GAP_CYC - 1);
        end
      end
      PASS1: begin
        pix_d  = s1_pix;
        drop0  = start0;
        perr_h = s1_pix.hsync & ~s1_pix.vsync;
        perr_v = s1_pix.vsync & ~s1_pix.fsync;
        if (!s1_pix.fsync) begin
          state_d = GAP;
          gap_d   = GAP_W'(NUM_GAP_CYC - 1);
        end
      end
      GAP: begin
        // Nobody is granted during the flush, so any start here is lost.
        drop0 = start0;
        drop1 = start1;
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear first, then apply this cycle's events so a coincident event survives.
  always_comb begin
    cnt0_base = i_err_clr ? 8'd0 : cnt0_q;
    cnt1_base = i_err_clr ? 8'd0 : cnt1_q;
    err_base  = i_err_clr ? 4'd0 : err_q;
    cnt0_d    = drop0 ? sat_inc(cnt0_base) : cnt0_base;
    cnt1_d    = drop1 ? sat_inc(cnt1_base) : cnt1_base;
    err_d     = err_base | {perr_v, perr_h, drop1, drop0};
  end

  // Stage p1: registered converter input and arbiter state.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      grant_q  <= 1'b1;
      fs_prev0 <= 1'b1;
      fs_prev1 <= 1'b1;
      cnt0_q   <= 8'd0;
      cnt1_q   <= 8'd0;
      err_q    <= 4'd0;
      pix_p1   <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      fs_prev0 <= s0_pix.fsync;
      fs_prev1 <= s1_pix.fsync;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      err_q    <= err_d;
      pix_p1   <= pix_d;
    end
  end

  assign m_img_rgb888_c_fsync = pix_p1.fsync;
  assign m_img_rgb888_c_vsync = pix_p1.vsync;
  assign m_img_rgb888_c_hsync = pix_p1.hsync;
  assign m_img_rgb888_r_mdat0 = pix_p1.r;
  assign m_img_rgb888_g_mdat1 = pix_p1.g;
  assign m_img_rgb888_b_mdat2 = pix_p1.b;
  assign o_grant_src          = grant_q;
  assign o_grant_busy         = (state_q != IDLE);
  assign o_drop_cnt0          = cnt0_q;
  assign o_drop_cnt1          = cnt1_q;
  assign m_err_arb_info       = WD_ERR_INFO'(err_q);

endmodule
